// File: rtl/aes_stream_core.sv
// aes_stream_core: iterative AES encrypt engine (AES-128/192/256), one round per clock.
// Expands the key into an on-chip round-key store, then accepts plaintext blocks through a
// valid/ready input, runs NR rounds and hands the ciphertext to a one-entry output register.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   key, key_load, key_ready  key (word 0 in MSBs), load pulse, round keys valid
//   clear                     soft reset: drop key, in-flight block and pending output
//   in_valid/in_ready/in_data/in_tag      plaintext stream (byte 0 in [127:120]) plus opaque tag
//   out_valid/out_ready/out_data/out_tag  ciphertext stream plus the tag of that block
//   busy                      key expansion or a block in flight
module aes_stream_core #(
  parameter int KEY_BITS = 256,
  parameter int TAG_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key,
  input  logic                key_load,
  output logic                key_ready,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] LAST_W = IW'(NW - 1);
  localparam logic [IW-1:0] NK_W   = IW'(NK);
  localparam logic [3:0]    NR_R   = 4'(NR);
  localparam logic [2:0]    NK_M1  = 3'(NK - 1);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
    $fatal(1, "aes_stream_core: KEY_BITS must be 128, 192 or 256");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, acc;
    p   = a;
    acc = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ p;
      p = xt(p);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (a^254 = a^2*a^4*...*a^128, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, inv;
    p   = a;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // SubBytes and ShiftRows together; state is column-major, row r of column c at byte 4c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-32*c-8*row -: 8] = sbox(s[127-32*((c+row)%4)-8*row -: 8]);
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

  typedef enum logic [2:0] {IDLE, KEY_EXP, READY, ROUND, STALL} state_t;
  state_t state, state_nxt;

  logic [31:0]      w_mem [NW];
  logic [IW-1:0]    widx;
  logic [2:0]       kmod;
  logic [7:0]       rcon;
  logic [31:0]      w_prev, w_old, w_tmp, w_new;
  logic [127:0]     blk_p0;
  logic [TAG_W-1:0] tag_p0;
  logic [3:0]       rnd;
  logic [IW-1:0]    rk_idx;
  logic [127:0]     rk, rk0, sr, rnd_out;
  logic             accept, out_free, last_rnd, final_wr;

  assign key_ready = (state == READY) || (state == ROUND) || (state == STALL);
  assign busy      = (state == KEY_EXP) || (state == ROUND) || (state == STALL);

  // Key schedule: kmod tracks i%NK without a divider, rcon advances each time it is consumed.
  always_comb begin
    w_prev = w_mem[widx - IW'(1)];
    w_old  = w_mem[widx - NK_W];
    w_tmp  = w_prev;
    if (kmod == 3'd0)                  w_tmp = subword({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h0};
    else if (NK == 8 && kmod == 3'd4)  w_tmp = subword(w_prev);
    w_new  = w_old ^ w_tmp;
  end

  assign rk_idx  = IW'({rnd, 2'b00});
  assign rk      = {w_mem[rk_idx], w_mem[rk_idx + IW'(1)], w_mem[rk_idx + IW'(2)], w_mem[rk_idx + IW'(3)]};
  assign rk0     = {w_mem[0], w_mem[1], w_mem[2], w_mem[3]};
  assign sr      = sub_shift(blk_p0);
  assign rnd_out = (last_rnd ? sr : mix_cols(sr)) ^ rk;

  // clear beats key_load, which beats any handshake; key_load in any state restarts expansion.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == READY) && !key_load && !clear;
    accept    = in_ready && in_valid;
    out_free  = !out_valid || out_ready;
    last_rnd  = (rnd == NR_R);
    final_wr  = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else if (key_load) begin
      state_nxt = KEY_EXP;
    end else begin
      unique case (state)
        KEY_EXP: if (widx == LAST_W) state_nxt = READY;
        READY:   if (accept) state_nxt = ROUND;
        ROUND: begin
          if (last_rnd) begin
            if (out_free) begin
              final_wr  = 1'b1;
              state_nxt = READY;
            end else begin
              state_nxt = STALL;
            end
          end
        end
        STALL: begin
          if (out_free) begin
            final_wr  = 1'b1;
            state_nxt = READY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: key store and expansion counters
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      if (key_load) begin
        for (int k = 0; k < NK; k++) w_mem[k] <= key[KEY_BITS-1-32*k -: 32];
        widx <= NK_W;
        kmod <= 3'd0;
        rcon <= 8'h01;
      end else if (state == KEY_EXP) begin
        w_mem[widx] <= w_new;
        widx        <= widx + IW'(1);
        kmod        <= (kmod == NK_M1) ? 3'd0 : kmod + 3'd1;
        if (kmod == 3'd0) rcon <= xt(rcon);
      end
    end
  end

  // Stage p0: round state; the final round is left to the output register write
  always_ff @(posedge clk) begin
    if (accept) begin
      blk_p0 <= in_data ^ rk0;
      tag_p0 <= in_tag;
      rnd    <= 4'd1;
    end else if (state == ROUND && !last_rnd) begin
      blk_p0 <= rnd_out;
      rnd    <= rnd + 4'd1;
    end
  end

  // Stage p1: one-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (final_wr) begin
      out_valid <= 1'b1;
      out_data  <= rnd_out;
      out_tag   <= tag_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_aes_stream_core.sv
// tb_aes_stream_core: three engines (AES-128/192/256) driven with known-answer vectors.
// Expected ciphertext/tag pairs are queued when a block is sent; a negedge monitor pops and
// compares whenever an engine completes an output handshake.
`timescale 1ns/1ps
module tb_aes_stream_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0][255:0] key;
  logic [2:0]        key_load, clear, in_valid, out_ready;
  logic [2:0][127:0] in_data;
  logic [2:0][3:0]   in_tag;
  logic [2:0]        key_ready, in_ready, out_valid, busy;
  logic [2:0][127:0] out_data;
  logic [2:0][3:0]   out_tag;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KB = 128 + 64 * g;
    aes_stream_core #(.KEY_BITS(KB), .TAG_W(4)) u_dut (
      .clk(clk), .rst(rst), .key(key[g][255 -: KB]), .key_load(key_load[g]),
      .key_ready(key_ready[g]), .clear(clear[g]), .in_valid(in_valid[g]),
      .in_ready(in_ready[g]), .in_data(in_data[g]), .in_tag(in_tag[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .out_tag(out_tag[g]), .busy(busy[g])
    );
  end

  localparam logic [255:0] KEY_A128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_A192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_A256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_A     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_A192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_A256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_B128  = 128'h3925841d02dc09fbdc118597196a0b32;

  int checks   = 0;
  int failures = 0;

  logic [131:0] q0[$], q1[$], q2[$];

  function automatic void q_push(int g, logic [131:0] v);
    case (g)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int q_size(int g);
    case (g)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [131:0] q_front(int g);
    case (g)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic logic [131:0] q_pop(int g);
    case (g)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(string name, int g, logic [131:0] act, logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h required %h", name, g, act, exp);
    end
  endtask

  // Scoreboard monitor: held outputs must match the oldest pending expectation; every
  // completed handshake consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        if (out_valid[g] && !out_ready[g] && q_size(g) != 0)
          chk("hold_out", g, {out_tag[g], out_data[g]}, q_front(g));
        if (out_valid[g] && out_ready[g]) begin
          if (q_size(g) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out dut%0d: got tag %0d data %h, required no output",
                     g, out_tag[g], out_data[g]);
          end else begin
            chk("out_block", g, {out_tag[g], out_data[g]}, q_pop(g));
          end
        end
      end
    end
  end

  task automatic load_key(int g, logic [255:0] k, int exp_cyc);
    key[g]      = k;
    key_load[g] = 1'b1;
    @(posedge clk); #1;
    key_load[g] = 1'b0;
    repeat (exp_cyc - 1) @(posedge clk);
    @(negedge clk);
    chk("kexp_early", g, key_ready[g], 0);
    chk("kexp_busy", g, busy[g], 1);
    @(posedge clk);
    @(negedge clk);
    chk("kexp_done", g, key_ready[g], 1);
    chk("kexp_idle", g, busy[g], 0);
    @(posedge clk); #1;
  endtask

  task automatic send(int g, logic [127:0] d, logic [3:0] t, bit push, logic [127:0] ct, int lat);
    int n;
    in_data[g]  = d;
    in_tag[g]   = t;
    in_valid[g] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL accept_timeout dut%0d: got no in_ready in %0d cycles, required acceptance", g, n);
      in_valid[g] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
    if (push) q_push(g, {t, ct});
    if (lat > 0) begin
      repeat (lat - 1) @(posedge clk);
      @(negedge clk);
      chk("lat_early", g, out_valid[g], 0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_hit", g, out_valid[g], 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(int g);
    int n;
    n = 0;
    @(negedge clk);
    while ((q_size(g) != 0 || out_valid[g]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL drain_timeout dut%0d: got %0d pending, required 0", g, q_size(g));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    key = '0; key_load = '0; clear = '0; in_valid = '0; out_ready = '1;
    in_data = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_key_ready", g, key_ready[g], 0);
      chk("rst_in_ready", g, in_ready[g], 0);
      chk("rst_out_valid", g, out_valid[g], 0);
      chk("rst_busy", g, busy[g], 0);
      chk("rst_out", g, {out_tag[g], out_data[g]}, 0);
    end
    @(posedge clk); #1;

    // Known-answer vectors for each key size, with expansion time and latency.
    load_key(0, KEY_A128, 40);
    send(0, PT_A, 4'd1, 1'b1, CT_A128, 10);
    drain(0);
    load_key(1, KEY_A192, 46);
    send(1, PT_A, 4'd2, 1'b1, CT_A192, 12);
    drain(1);
    load_key(2, KEY_A256, 52);
    send(2, PT_A, 4'd3, 1'b1, CT_A256, 14);
    drain(2);

    // Backpressure: block 1 held, block 2 parked, then both delivered in order.
    out_ready[0] = 1'b0;
    send(0, PT_A, 4'd1, 1'b1, CT_A128, 10);
    send(0, PT_A, 4'd2, 1'b1, CT_A128, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_valid", 0, out_valid[0], 1);
    chk("stall_tag", 0, out_tag[0], 1);
    chk("stall_in_ready", 0, in_ready[0], 0);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("beat1_tag", 0, out_tag[0], 1);
    @(negedge clk);
    chk("beat2_valid", 0, out_valid[0], 1);
    chk("beat2_tag", 0, out_tag[0], 2);
    @(posedge clk); #1;
    drain(0);

    // Key reload during round 5: that block vanishes, next block uses the new key.
    send(0, PT_A, 4'd5, 1'b0, '0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 0, busy[0], 1);
    chk("mid_in_ready", 0, in_ready[0], 0);
    @(posedge clk); #1;
    load_key(0, KEY_B128, 40);
    send(0, PT_B, 4'd6, 1'b1, CT_B128, 10);
    drain(0);

    // clear together with key_load and in_valid while an output is held.
    out_ready[0] = 1'b0;
    send(0, PT_B, 4'd7, 1'b0, '0, 10);
    clear[0] = 1'b1; key_load[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = PT_A;
    @(negedge clk);
    chk("clr_in_ready", 0, in_ready[0], 0);
    @(posedge clk); #1;
    clear[0] = 1'b0; key_load[0] = 1'b0; in_valid[0] = 1'b0;
    @(negedge clk);
    chk("clr_key_ready", 0, key_ready[0], 0);
    chk("clr_out_valid", 0, out_valid[0], 0);
    chk("clr_busy", 0, busy[0], 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("clr_still_idle", 0, busy[0], 0);
    chk("clr_no_out", 0, out_valid[0], 0);
    @(posedge clk); #1;

    // rst pulse in the middle of key expansion.
    out_ready[0] = 1'b1;
    key[0] = KEY_A128; key_load[0] = 1'b1;
    @(posedge clk); #1;
    key_load[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 0, busy[0], 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_key_ready", 0, key_ready[0], 0);
    chk("mrst_in_ready", 0, in_ready[0], 0);
    chk("mrst_out_valid", 0, out_valid[0], 0);
    chk("mrst_busy", 0, busy[0], 0);
    chk("mrst_out", 0, {out_tag[0], out_data[0]}, 0);
    @(posedge clk); #1;
    load_key(0, KEY_A128, 40);
    send(0, PT_A, 4'd9, 1'b1, CT_A128, 10);
    drain(0);

    for (int g = 0; g < 3; g++) chk("queue_empty", g, q_size(g), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
